// File: rtl/cpu_pkg.sv
// Shared register-file constants and the drain FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

    localparam int REG_NUM = 32;  // number of architectural registers
    localparam int REG_AW  = 5;   // register index width, clog2(REG_NUM)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/prio_enc32.sv
// Lowest-set-bit encoder: returns the index of the least significant 1 in req.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
//
// Ports:
//   req  in   32-bit request vector
//   idx  out  index of the lowest set bit (0 when req is empty)
//   any  out  at least one bit of req is set
module prio_enc32 (
    input  logic [31:0] req,
    output logic [4:0]  idx,
    output logic        any
);

    // Walk from the top down so the last match, i.e. the lowest index, wins.
    always_comb begin
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (req[i]) begin
                idx = 5'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_index_encoder.sv
// Drains a 32-bit register mask into a stream of 5-bit indices, one per handshake.
// Latency: first index the cycle after a load; done pulses the cycle after the last handshake.
// Backpressure: idx_out/idx_valid/pending hold while idx_ready is low; req_load ignored while busy.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   req_vec    request mask, captured on req_load when not busy
//   req_load   load strobe
//   idx_out    index currently offered (valid only while idx_valid)
//   idx_valid  idx_out is valid (high only in SCAN)
//   idx_ready  consumer accepts idx_out this cycle
//   busy       block is scanning; loads are ignored
//   done       one-cycle pulse after the mask drains or after an empty load
//   pending    requests not yet served
//
// Build option: define RR_INDEX_ENCODER_RR_EN for round-robin selection, where the
// search starts just past the last index served and that pointer persists across
// loads. Without it the lowest pending index always goes first and no pointer exists.
module rr_index_encoder
    import cpu_pkg::*;
#(
    parameter int N = REG_NUM,
    parameter int W = REG_AW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_vec,
    input  logic         req_load,
    output logic [W-1:0] idx_out,
    output logic         idx_valid,
    input  logic         idx_ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] pending
);

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] pending_nxt;
    logic [N-1:0] rot;        // pending as seen from the search start point
    logic [W-1:0] enc_idx;    // lowest set bit of rot
    logic         enc_any;
    logic [W-1:0] idx_sel;    // enc_idx mapped back to an absolute register index
    logic [N-1:0] clr_mask;
    logic [N-1:0] pending_cleared;
    logic         hs;

`ifdef RR_INDEX_ENCODER_RR_EN
    logic [W-1:0] ptr;

    // Rotate right by ptr so bit ptr lands at position 0; the encoder then finds
    // the first request at or above ptr, wrapping past the top back to bit 0.
    // A shift by N (ptr == 0) yields zero, leaving the plain right shift.
    assign rot     = (pending >> ptr) | (pending << (N - int'(ptr)));
    assign idx_sel = enc_idx + ptr;  // W-bit add wraps modulo N

    // Served index plus one; index N-1 wraps naturally to 0 in W bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= idx_out + W'(1);
        end
    end
`else
    assign rot     = pending;
    assign idx_sel = enc_idx;
`endif

    prio_enc32 u_enc (
        .req (rot),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Outputs depend on registered state only. pending is never empty in SCAN,
    // so the enc_any term is a guard rather than a functional qualifier.
    assign idx_valid = (state == SCAN) && enc_any;
    assign idx_out   = (state == SCAN) ? idx_sel : '0;
    assign busy      = (state == SCAN);
    assign done      = (state == DONE);

    assign hs              = idx_valid && idx_ready;
    assign clr_mask        = {{(N-1){1'b0}}, 1'b1} << idx_sel;
    assign pending_cleared = pending & ~clr_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                if (req_load) begin
                    pending_nxt = req_vec;
                    state_nxt   = (req_vec != '0) ? SCAN : DONE;
                end
            end
            DONE: begin
                if (req_load) begin
                    pending_nxt = req_vec;
                    state_nxt   = (req_vec != '0) ? SCAN : DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SCAN: begin
                // req_load is deliberately not looked at here.
                if (hs) begin
                    pending_nxt = pending_cleared;
                    if (pending_cleared == '0) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                pending_nxt = '0;
            end
        endcase
    end

endmodule

// File: doc/rr_index_encoder.md
Name: rr_index_encoder

Overview:
- Inverse of the register-file write-address one-hot decoder: converts a 32-bit request vector into a stream of 5-bit register indices, one per handshake.
- Used by the write-back/scoreboard logic to drain a multi-register pending mask (e.g. registers to clear or flush) through a single regfile port.
- Round-robin or fixed-priority selection; valid/ready output handshake.

Parameters:
- N, 32, request vector width (number of registers).
- W, 5, index width; fixed at clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_vec  input  N  request mask; sampled only when req_load=1 and block is not busy.
- req_load  input  1  load strobe.
- idx_out  output  W  index of the currently offered request.
- idx_valid  output  1  idx_out is valid.
- idx_ready  input  1  consumer accepts idx_out this cycle.
- busy  output  1  high in SCAN; req_load is ignored while high.
- done  output  1  one-cycle pulse after the mask is fully drained, or after an empty load.
- pending  output  N  remaining unserved requests (debug/visibility).

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high: ports clk and rst.
- Reset values (rst=1 at an edge, mid-operation included): state=IDLE, pending=0, ptr=0, idx_valid=0, idx_out=0, busy=0, done=0. Any in-flight scan is abandoned and no further indices are issued.
- State machine: IDLE, SCAN, DONE.
- IDLE or DONE with req_load=1:
  - pending<=req_vec.
  - If req_vec!=0, next state is SCAN.
  - If req_vec==0, next state is DONE.
  - ptr is not modified by a load.
- IDLE with req_load=0: stay in IDLE. DONE with req_load=0: go to IDLE.
- DONE lasts one cycle. done=1 only in DONE; busy=0 in DONE.
- SCAN:
  - idx_valid=1, busy=1.
  - idx_out is the first set bit of pending searching upward from ptr, wrapping 31->0.
  - Outputs are combinational from registered state only; there is no input-to-output path.
- Handshake (idx_valid & idx_ready at an edge):
  - Clear pending[idx_out].
  - ptr<=(idx_out+1) mod 32; index 31 wraps ptr to 0.
  - If the cleared bit was the last set bit, next state is DONE, else stay in SCAN.
- Backpressure: while idx_ready=0, idx_out, idx_valid and pending hold stable.
- req_load during SCAN is ignored; pending is unaffected.
- Latency:
  - Load at edge T: first idx_valid in the cycle after T.
  - Last handshake at edge T: done=1 in the cycle after T, IDLE the cycle after that.
- Throughput: one index per cycle when idx_ready is held high.
- idx_valid is never high in IDLE or DONE.

Optional Feature:
- Macro: RR_INDEX_ENCODER_RR_EN.
- Defined: round-robin selection as above; ptr persists across loads.
- Undefined: fixed priority. Search always starts at bit 0, giving the lowest index first. ptr is held at 0, and ptr logic is not synthesized.

Decomposition:
- Shared package (cpu_pkg):
  - constants REG_NUM=32, REG_AW=5.
  - state enum {IDLE, SCAN, DONE}.
- Sub-module prio_enc32: combinational lowest-set-bit encoder with a 32-bit input, 5-bit index output and 1-bit any output.
- Parent rotates pending right by ptr, encodes, then adds ptr mod 32 to form idx_out.

Test Plan:
- Reset, then load 0x0000_0011 with ready=1 -> idx_out 0 then 4 on consecutive cycles, then done pulse, then IDLE; ptr=5.
- From ptr=5, load 0x8000_0021 -> indices 5, 31, 0 (wrap); done after the third handshake. With RR_INDEX_ENCODER_RR_EN undefined, the same load gives 0, 5, 31.
- Load 0x0000_0000 -> done=1 for exactly one cycle on the next cycle; idx_valid never asserted.
- Load 0x0000_0300, hold idx_ready=0 for 3 cycles -> idx_out=8 and idx_valid=1 stable for all 3 cycles. Then ready=1 gives 8 then 9.
- During SCAN of 0x0000_000F, pulse req_load with 0xFFFF_0000 -> ignored; only 0, 1, 2, 3 issued; pending never shows upper bits.
- Assert rst after 2 handshakes of 0x0000_00FF -> next cycle idx_valid=0, pending=0, done=0, busy=0. A subsequent load of 0x0000_0004 yields idx 2 (ptr reset to 0).
